led_matrix_column_scanner: RTL and testbench
============================================

Name: led_matrix_column_scanner

Overview:
- Time-multiplexes the 5x7 LED matrix. Consumes the 7-bit row images produced by the per-column irrigation status decoders (columns 0..4). Drives one column at a time with its row pattern.
- A blanking gap between columns suppresses ghosting. A frame-level shadow register keeps the image stable (tear-free) within a frame.
- Sits between the status decoders and the matrix pins.

Parameters:
- CLK_DIV, 1000: clock cycles per column slot. Legal range 4..65535.
- BLANK_CYCLES, 16: cycles at the start of each slot with every column and row off. Must satisfy 1 <= BLANK_CYCLES < CLK_DIV.
- COL_ACTIVE_LOW, 0: 1 means col_select is driven active-low at the pins.
- ROW_ACTIVE_LOW, 0: 1 means row_drive is driven active-low at the pins.
- BLINK_FRAMES, 50: frames per blink half-period. Used only with the optional feature.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- frame_data  input  35  decoder outputs, {col4,col3,col2,col1,col0}; each field is 7 bits, bit r = row r lit
- blink_req  input  1  request display blink; used only with the optional feature
- col_select  output  5  one-hot column enable (polarity per COL_ACTIVE_LOW)
- row_drive  output  7  row pattern of the active column (polarity per ROW_ACTIVE_LOW)
- current_col  output  3  index of the slot in progress, 0..4
- frame_start  output  1  one-cycle pulse when the column-0 slot begins

Behaviour:
- Reset (reset_n low, asynchronous):
  - slot counter = 0, column index = 0, state = BLANK, shadow = 0.
  - col_select and row_drive at their inactive levels: all 0 if active-high, all 1 if active-low.
  - current_col = 0, frame_start = 0.
- All outputs are registered. Pins reflect the internal state one cycle after it changes.
- Slot counter runs 0..CLK_DIV-1 and wraps.
- States:
  - BLANK while counter < BLANK_CYCLES.
  - DRIVE while counter >= BLANK_CYCLES.
  - BLANK -> DRIVE at counter == BLANK_CYCLES.
  - DRIVE -> BLANK when the counter wraps. At the same time the column index increments, 4 wraps to 0.
- BLANK: col_select all inactive, row_drive all inactive.
- DRIVE: col_select[current_col] active, all other bits inactive. row_drive = shadow field for current_col.
- Shadow capture:
  - frame_data is sampled into shadow on the clock edge that begins the column-0 slot (counter wraps to 0 with index wrapping to 0).
  - The first slot after reset also captures, at the first clock after reset_n deasserts.
  - Changes to frame_data mid-frame are not visible until the next frame.
- frame_start:
  - Asserts for exactly one cycle, registered, aligned with the capture edge (first cycle of the col-0 BLANK).
  - Period = 5*CLK_DIV cycles.
- current_col updates on the first cycle of each slot and holds for CLK_DIV cycles.
- Frame length: 5*CLK_DIV cycles. Each column is lit for CLK_DIV-BLANK_CYCLES cycles per frame.
- Never more than one column active. No cycle where a column is active while row_drive carries another column's data.
- Reset asserted mid-slot: outputs go inactive immediately (asynchronous). After release, scanning restarts at column 0, BLANK, with a fresh capture.
- Unknown/X on frame_data only affects row_drive. It never affects the column sequencing.

Optional Feature:
- Macro: LED_MATRIX_BLINK_EN.
- Defined:
  - A frame counter (0..BLINK_FRAMES-1) advances on each frame_start and drives a blink phase bit that toggles on each wrap.
  - While blink_req = 1 and the phase bit = 1, DRIVE behaves like BLANK (everything inactive). Sequencing and frame_start are unchanged.
  - blink_req is sampled only at frame_start, so a frame is never partially blanked.
  - Reset clears the frame counter and sets phase = 0 (display visible).
- Undefined: blink_req is ignored, no frame counter is built, and the display is always driven.

Test Plan (CLK_DIV=8, BLANK_CYCLES=2, polarities 0 unless stated):
- Reset release, frame_data col0=7'h41, col1=7'h7F -> frame_start pulses at cycle 1 after release. col_select=5'b00001 with row_drive=7'h41 for 6 cycles, preceded by 2 cycles of 0/0. Then col_select=5'b00010 with row_drive=7'h7F.
- Run 3 frames -> frame_start period exactly 40 cycles. current_col sequence 0,1,2,3,4,0. col_select never has more than one bit set.
- Change col3 data from 7'h00 to 7'h1C while column 1 is in DRIVE -> column 3 still shows 7'h00 this frame and 7'h1C the next frame.
- COL_ACTIVE_LOW=1, ROW_ACTIVE_LOW=1 -> during BLANK col_select=5'h1F and row_drive=7'h7F. Column 2 in DRIVE gives col_select=5'b11011 and row_drive = inverted col2 data.
- Assert reset_n low at counter 5 of column 3 -> outputs inactive in the same cycle. After release, current_col=0 and the state is BLANK.
- With LED_MATRIX_BLINK_EN, BLINK_FRAMES=2, blink_req=1 -> frames 0-1 driven, frames 2-3 fully blank, frames 4-5 driven. With blink_req=0 every frame is driven.

Source files
------------

// File: rtl/led_matrix_column_scanner_if.sv
// Bundle between the column scanner and its neighbours: decoder images in, matrix pins out.
// Latency: n/a (signal bundle only).
// Backpressure: none; frame_data is sampled, pins are free-running.
interface led_matrix_column_scanner_if;
   logic [34:0] frame_data;   // {col4,col3,col2,col1,col0}, bit r of a field = row r lit
   logic        blink_req;    // display blink request, read only when blink support is built
   logic [4:0]  col_select;   // one-hot column enable at pin polarity
   logic [6:0]  row_drive;    // row pattern of the active column at pin polarity
   logic [2:0]  current_col;  // slot in progress, 0..4
   logic        frame_start;  // one-cycle pulse at the start of the column-0 slot

   // Scanner side: consumes decoder images, drives the matrix pins.
   modport master (
      input  frame_data,
      input  blink_req,
      output col_select,
      output row_drive,
      output current_col,
      output frame_start
   );

   // Environment side: supplies decoder images, observes the matrix pins.
   modport slave (
      output frame_data,
      output blink_req,
      input  col_select,
      input  row_drive,
      input  current_col,
      input  frame_start
   );
endinterface

// File: rtl/led_matrix_column_scanner.sv
// Time-multiplexes the 5x7 LED matrix one column per slot, blanking the start of each slot.
// Latency: pins are registered, one cycle behind the slot counter; new frame_data shows next frame.
// Backpressure: none; scans continuously. Blink support is built only with LED_MATRIX_BLINK_EN.
module led_matrix_column_scanner #(
   parameter int CLK_DIV        = 1000,  // cycles per column slot, 4..65535
   parameter int BLANK_CYCLES   = 16,    // dark cycles at slot start, 1..CLK_DIV-1
   parameter int COL_ACTIVE_LOW = 0,     // 1: col_select active-low at the pins
   parameter int ROW_ACTIVE_LOW = 0,     // 1: row_drive active-low at the pins
   parameter int BLINK_FRAMES   = 50     // frames per blink half-period
) (
   input  logic                          clk,
   input  logic                          reset_n,
   led_matrix_column_scanner_if.master   bus
);

   // ------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------
   localparam int              CW             = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0]   CNT_LAST       = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0]   CNT_BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [2:0]      COL_FIRST      = 3'd0;
   localparam logic [2:0]      COL_LAST       = 3'd4;
   localparam logic            COL_INV        = (COL_ACTIVE_LOW != 0);
   localparam logic            ROW_INV        = (ROW_ACTIVE_LOW != 0);

   localparam logic [0:0]      ST_BLANK       = 1'b0;
   localparam logic [0:0]      ST_DRIVE       = 1'b1;

   // ------------------------------------------------------------------
   // Scan state
   // ------------------------------------------------------------------
   logic [CW-1:0] cnt;          // position inside the current slot
   logic [2:0]    col;          // column owning the current slot
   logic [0:0]    state;        // BLANK / DRIVE, always consistent with cnt
   logic [34:0]   shadow;       // frame image, frozen for a whole frame
   logic          slot_end;     // last cycle of a slot
   logic          frame_begin;  // first cycle of the column-0 slot
   logic          visible;      // low when the whole frame is blinked off
   logic [4:0]    col_raw;      // active-high column enable for this position
   logic [6:0]    row_raw;      // active-high row pattern for this position

   // Slot boundaries, decoded from the counter only so frame_data can never disturb sequencing.
   always_comb begin
      slot_end    = (cnt == CNT_LAST);
      frame_begin = (cnt == '0) && (col == COL_FIRST);
   end

   // Slot counter, column index and BLANK/DRIVE state advance together every cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt   <= '0;
         col   <= COL_FIRST;
         state <= ST_BLANK;
      end else if (slot_end) begin
         cnt   <= '0;
         state <= ST_BLANK;
         col   <= (col == COL_LAST) ? COL_FIRST : col + 3'd1;
      end else begin
         cnt <= cnt + CW'(1);
         if (cnt == CNT_BLANK_LAST) begin
            state <= ST_DRIVE;
         end
      end
   end

   // Frame image is taken once per frame, at the column-0 slot start (including the first
   // slot after reset), so mid-frame decoder changes cannot tear the display.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow <= '0;
      end else if (frame_begin) begin
         shadow <= bus.frame_data;
      end
   end

`ifdef LED_MATRIX_BLINK_EN
   // ------------------------------------------------------------------
   // Blink: a frame counter toggles a phase bit every BLINK_FRAMES frames.
   // The blank decision is latched at frame start, so a frame is all-on or all-off.
   // ------------------------------------------------------------------
   localparam int            FW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

   logic [FW-1:0] frame_cnt;
   logic          phase;        // 0: visible half-period, 1: blinkable half-period
   logic          frame_blank;  // current frame is blinked off

   // Advance the blink phase on each frame start and decide the fate of the new frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt   <= '0;
         phase       <= 1'b0;
         frame_blank <= 1'b0;
      end else if (frame_begin) begin
         frame_blank <= bus.blink_req & phase;
         if (frame_cnt == FRAME_LAST) begin
            frame_cnt <= '0;
            phase     <= ~phase;
         end else begin
            frame_cnt <= frame_cnt + FW'(1);
         end
      end
   end

   assign visible = ~frame_blank;
`else
   // Blink request and frame count are not used in this build; the display is always driven.
   localparam int blink_frames_unused = BLINK_FRAMES;
   logic          blink_req_unused;

   assign blink_req_unused = bus.blink_req;
   assign visible          = 1'b1;
`endif

   // Column enable and row pattern for the current position, both taken from the same
   // column index so rows can never carry another column's data.
   always_comb begin
      col_raw = '0;
      row_raw = '0;
      if ((state == ST_DRIVE) && visible) begin
         case (col)
            3'd0: begin
               col_raw = 5'b00001;
               row_raw = shadow[6:0];
            end
            3'd1: begin
               col_raw = 5'b00010;
               row_raw = shadow[13:7];
            end
            3'd2: begin
               col_raw = 5'b00100;
               row_raw = shadow[20:14];
            end
            3'd3: begin
               col_raw = 5'b01000;
               row_raw = shadow[27:21];
            end
            3'd4: begin
               col_raw = 5'b10000;
               row_raw = shadow[34:28];
            end
            default: begin
               col_raw = '0;
               row_raw = '0;
            end
         endcase
      end
   end

   // Pin registers: reset forces every pin to its inactive level immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.col_select  <= {5{COL_INV}};
         bus.row_drive   <= {7{ROW_INV}};
         bus.current_col <= COL_FIRST;
         bus.frame_start <= 1'b0;
      end else begin
         bus.col_select  <= col_raw ^ {5{COL_INV}};
         bus.row_drive   <= row_raw ^ {7{ROW_INV}};
         bus.current_col <= col;
         bus.frame_start <= frame_begin;
      end
   end

endmodule

// File: tb/tb_led_matrix_column_scanner.sv
// Bench for led_matrix_column_scanner: two instances (active-high and active-low pins)
// share one stimulus; a frame-level reference model predicts every pin cycle and a
// monitor compares both instances against it.
`timescale 1ns/1ps
module tb_led_matrix_column_scanner;

   localparam int D     = 8;      // CLK_DIV
   localparam int B     = 2;      // BLANK_CYCLES
   localparam int BF    = 2;      // BLINK_FRAMES
   localparam int FRAME = 5 * D;

   typedef struct packed {
      logic [4:0] cs;
      logic [6:0] rd;
      logic [2:0] cc;
      logic       fs;
   } pins_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [34:0] frame_data = '0;
   logic        blink_req = 1'b0;

   always #5 clk = ~clk;

   led_matrix_column_scanner_if bus_a ();
   led_matrix_column_scanner_if bus_b ();

   assign bus_a.frame_data = frame_data;
   assign bus_a.blink_req  = blink_req;
   assign bus_b.frame_data = frame_data;
   assign bus_b.blink_req  = blink_req;

   led_matrix_column_scanner #(
      .CLK_DIV(D), .BLANK_CYCLES(B), .COL_ACTIVE_LOW(0), .ROW_ACTIVE_LOW(0), .BLINK_FRAMES(BF)
   ) dut_a (
      .clk(clk), .reset_n(reset_n), .bus(bus_a)
   );

   led_matrix_column_scanner #(
      .CLK_DIV(D), .BLANK_CYCLES(B), .COL_ACTIVE_LOW(1), .ROW_ACTIVE_LOW(1), .BLINK_FRAMES(BF)
   ) dut_b (
      .clk(clk), .reset_n(reset_n), .bus(bus_b)
   );

   int    n_cmp = 0;
   int    n_bad = 0;
   pins_t exp_q[$];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s at %0t: got cs=%b rd=%h cc=%0d fs=%b, want cs=%b rd=%h cc=%0d fs=%b",
                  name, $time, act[15:11], act[10:4], act[3:1], act[0],
                  req[15:11], req[10:4], req[3:1], req[0]);
      end
   endtask

   function automatic logic [15:0] pins_of_a();
      return {bus_a.col_select, bus_a.row_drive, bus_a.current_col, bus_a.frame_start};
   endfunction

   function automatic logic [15:0] pins_of_b();
      return {bus_b.col_select, bus_b.row_drive, bus_b.current_col, bus_b.frame_start};
   endfunction

   function automatic logic [15:0] invert_pins(input pins_t e);
      return {~e.cs, ~e.rd, e.cc, e.fs};
   endfunction

   // Reference model: the frame position follows from the count of edges since reset
   // release; the image and blink decision are taken at each frame's first edge.
   initial begin
      int          t_rel;
      int          pos;
      int          k;
      int          c;
      logic [34:0] sh_m;
      bit          blank_m;
      pins_t       e;
      t_rel   = 0;
      sh_m    = '0;
      blank_m = 1'b0;
      forever begin
         @(posedge clk);
         if (!reset_n) begin
            t_rel = 0;
            e     = '0;
            exp_q.push_back(e);
         end else begin
            pos = t_rel % FRAME;
            k   = pos / D;
            c   = pos % D;
            if (pos == 0) begin
               sh_m = frame_data;
`ifdef LED_MATRIX_BLINK_EN
               blank_m = blink_req && ((((t_rel / FRAME) / BF) % 2) == 1);
`else
               blank_m = 1'b0;
`endif
            end
            e    = '0;
            e.cc = k[2:0];
            e.fs = (pos == 0);
            if (c >= B && !blank_m) begin
               e.cs = 5'(1 << k);
               e.rd = sh_m[k*7 +: 7];
            end
            exp_q.push_back(e);
            t_rel++;
         end
      end
   end

   // Monitor: after each edge, pop the prediction and compare both instances.
   initial begin
      pins_t m;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty at %0t: got no prediction, want one per cycle", $time);
         end else begin
            m = exp_q.pop_front();
            check("pins_active_high", pins_of_a(), m);
            check("pins_active_low", pins_of_b(), invert_pins(m));
            n_cmp++;
            if ($countones(bus_a.col_select) > 1) begin
               n_bad++;
               $display("FAIL one_hot at %0t: got col_select=%b, want at most one bit set",
                        $time, bus_a.col_select);
            end
         end
      end
   end

   // Stimulus: negedge-aligned, counts negedges since release (k-1 = index of last edge).
   int k_neg = 0;

   task automatic step(input int n, input bit rand_data, input bit rand_blink);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         k_neg++;
         if (rand_data && $urandom_range(5) == 0) begin
            frame_data = 35'({$urandom(), $urandom()});
         end
         if (rand_blink && $urandom_range(12) == 0) begin
            blink_req = ~blink_req;
         end
      end
   endtask

   initial begin
      reset_n    = 1'b0;
      frame_data = '0;
      blink_req  = 1'b0;
      repeat (3) @(negedge clk);

      // First frame: col0=41, col1=7F, col3=00, then col3 changes while col1 is driving.
      frame_data = {7'h55, 7'h00, 7'h2A, 7'h7F, 7'h41};
      blink_req  = 1'b1;
      reset_n    = 1'b1;
      k_neg      = 0;
      step(12, 1'b0, 1'b0);
      frame_data[27:21] = 7'h1C;
      step(FRAME - 12 + FRAME, 1'b0, 1'b0);

      // Blink requested through frames 2-3, then released for frames 4-7.
      step(2 * FRAME, 1'b1, 1'b0);
      blink_req = 1'b0;
      step(4 * FRAME, 1'b1, 1'b0);

      // Fully random data and blink request.
      step(3 * FRAME, 1'b1, 1'b1);

      // Reach counter 5 of column 3 on the pins, then reset asynchronously mid-cycle.
      while ((k_neg % FRAME) != (3 * D + 6)) step(1, 1'b1, 1'b1);
      reset_n = 1'b0;
      #1;
      check("async_reset_active_high", pins_of_a(), 16'h0000);
      check("async_reset_active_low", pins_of_b(), {5'h1F, 7'h7F, 3'd0, 1'b0});
      repeat (2) @(negedge clk);
      frame_data = {$urandom(), 3'b101};
      blink_req  = 1'b1;
      reset_n    = 1'b1;
      k_neg      = 0;
      step(3 * FRAME, 1'b1, 1'b1);
      step(2, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
